// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state encoding, MIPS opcode constants and operand-use helper
package pipeline_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  function automatic logic uses_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
  endfunction
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the load in EX and the source operands in ID
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [5:0] ifid_op_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       lu_stall_o
);
  assign lu_stall_o = idex_memread_i && idex_rt_i != 5'd0 &&
                      (idex_rt_i == ifid_rs_i || (uses_rt(ifid_op_i) && idex_rt_i == ifid_rt_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer with stalls, flushes, memory waits, drain and perf counters
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       ifid_op_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             dmem_req_o,
  output logic             running_o,
  output logic             halted_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam logic [31:0] TO = 32'(MEM_TIMEOUT);
  localparam logic [31:0] DC = 32'(DRAIN_CYCLES);
  state_t           state_q;
  logic [31:0]      wait_q, drain_q;
  logic [CNT_W-1:0] cycle_q, stall_q, cycle_d, stall_d;
  logic             err_q, lu, mem_req, mem_hold, frz_run, go, dr_go, hlt, timeout, active, stall_inc;
  hazard_detect u_hazard (
    .idex_memread_i(idex_memread_i),
    .idex_rt_i     (idex_rt_i),
    .ifid_op_i     (ifid_op_i),
    .ifid_rs_i     (ifid_rs_i),
    .ifid_rt_i     (ifid_rt_i),
    .lu_stall_o    (lu)
  );
  // go: the pipeline advances normally this cycle; dr_go: a drain cycle that advances
  assign mem_req   = exmem_memread_i | exmem_memwrite_i;
  assign mem_hold  = mem_req & ~dmem_ready_i;
  assign frz_run   = state_q == S_RUN & mem_hold;
  assign go        = (state_q == S_RUN & ~mem_hold) | (state_q == S_MEM_WAIT & dmem_ready_i);
  assign dr_go     = state_q == S_DRAIN & ~mem_hold;
  assign hlt       = state_q == S_RUN & go & ~lu & ifid_op_i == OP_HALT;
  assign timeout   = TO != 32'd0 && wait_q + 32'd1 == TO;
  assign active    = state_q == S_RUN | state_q == S_MEM_WAIT | state_q == S_DRAIN;
  assign stall_inc = state_q == S_MEM_WAIT | (go & lu);
  assign cycle_d   = cycle_q + {{(CNT_W-1){1'b0}}, active && cycle_q != '1};
  assign stall_d   = stall_q + {{(CNT_W-1){1'b0}}, stall_inc && stall_q != '1};
  assign pc_write_o     = go & ~lu & ~hlt;
  assign ifid_write_o   = go & ~lu;
  assign ifid_flush_o   = go & ~lu & (branch_taken_i | hlt);
  assign idex_write_o   = go | dr_go;
  assign idex_bubble_o  = go ? (lu | hlt) : ~(frz_run | state_q == S_MEM_WAIT);
  assign exmem_write_o  = go | dr_go;
  assign memwb_bubble_o = ~(go | dr_go);
  assign dmem_req_o     = state_q == S_MEM_WAIT | ((state_q == S_RUN | state_q == S_DRAIN) & mem_req);
  assign running_o      = state_q == S_RUN | state_q == S_MEM_WAIT;
  assign halted_o       = state_q == S_HALTED;
  assign mem_err_o      = err_q;
  assign cycle_cnt_o    = cycle_q;
  assign stall_cnt_o    = stall_q;
  // sequencer state, wait/drain counters, sticky error and saturating perf counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      case (state_q)
        S_IDLE: if (start_i) state_q <= S_RUN;
        S_RUN: begin
          if (mem_hold) begin
            state_q <= S_MEM_WAIT;
            wait_q  <= '0;
          end else if (hlt) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
            wait_q  <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready_i) begin
            state_q <= S_RUN;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + 32'd1;
            if (timeout) begin
              err_q   <= 1'b1;
              state_q <= S_HALTED;
            end
          end
        end
        S_DRAIN: begin
          if (mem_hold) begin
            wait_q <= wait_q + 32'd1;
            if (timeout) begin
              err_q   <= 1'b1;
              state_q <= S_HALTED;
            end
          end else begin
            wait_q  <= '0;
            drain_q <= drain_q + 32'd1;
            if (drain_q + 32'd1 >= DC) state_q <= S_HALTED;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
